rj_load_ctrl: RTL
=================

Name: rj_load_ctrl

Overview:
Sequencing controller for the 16x16 Rj coefficient memory (R_MEM).
- Deserializes MSB-first 16-bit coefficient words from the serial input, framed by Frame.
- Writes each completed word into consecutive memory addresses and owns the memory's write_enable, Frame, Write_Address and data_in pins.
- After a full coefficient set is loaded, grants the downstream MAC datapath read access through a req/ack handshake.

Parameters:
DATA_W, 16, serial word width and memory data width
ADDR_W, 4, memory address width
N_WORDS, 16, words per coefficient set; must be ≤ 2**ADDR_W

Ports:
Sclk  in  1  system clock; all logic runs on the rising edge (memory writes on the falling edge)
Reset_n  in  1  synchronous active-low reset
Frame  in  1  serial frame marker; high for one cycle, coincident with the MSB of a word
InputL  in  1  serial data bit, sampled every rising edge
load_start  in  1  one-cycle pulse; begins loading a new coefficient set
rd_req  in  1  datapath read request
rd_addr  in  ADDR_W  datapath read address, valid with rd_req
write_enable  out  1  memory write enable
mem_frame  out  1  drives the memory Frame pin; high only together with write_enable
Write_Address  out  ADDR_W  memory write address
data_in  out  DATA_W  memory write data
read_enable  out  1  memory read enable
Read_Address  out  ADDR_W  memory read address
rd_ack  out  1  the memory Rj output is valid for the granted address this cycle
rj_ready  out  1  full set loaded; reads permitted
busy  out  1  state is LOAD
frame_err  out  1  sticky; a Frame arrived mid-word; cleared by load_start or reset

Behaviour:
- Reset (Reset_n=0 at a rising edge):
  - state=IDLE; all outputs 0; shift register, bit count and word count cleared.
  - Reset mid-load discards all partial data; rj_ready stays 0 until a complete new load.
- States are IDLE, LOAD and READY.
  - IDLE: load_start -> LOAD. Frame and InputL are ignored.
  - LOAD: busy=1, rj_ready=0.
  - READY: rj_ready=1. load_start -> LOAD and clears rj_ready the next cycle.
  - load_start during LOAD restarts the set: word count=0, partial word dropped.
- Shifting (LOAD only):
  - Frame=1 loads InputL as the MSB and sets bit count=1.
  - Each following cycle shifts in one bit.
  - When bit count reaches DATA_W, the word is complete: latch it into a holding register, set bit count to 0 and wait for the next Frame.
  - Frame=1 while bit count is between 1 and DATA_W-1 sets frame_err, drops the partial word and starts a new word with this bit as MSB.
  - Back-to-back words are supported: a Frame in the cycle right after the last bit is accepted.
- Write pulse:
  - One cycle after a word completes, drive write_enable=1, mem_frame=1, Write_Address=word count, data_in=holding register, all for exactly one cycle.
  - The memory captures the write on the falling edge inside that cycle.
  - Word count increments at the end of the write cycle.
  - After the write of word N_WORDS-1, state becomes READY on the next edge. Word count wraps to 0.
  - Outside write cycles, write_enable=mem_frame=0. Write_Address and data_in hold their last values.
- Read handshake:
  - In READY, rd_req=1 at edge k gives read_enable=1, Read_Address=rd_addr (sampled at k) and rd_ack=1 during cycle k+1. Latency is 1.
  - Continuous rd_req gives one read per cycle.
  - In IDLE or LOAD, rd_req is not granted: rd_ack=0, read_enable=0. The requester holds rd_req.
  - Writes always take priority; read and write are never active in the same cycle.
- rd_addr ≥ N_WORDS is granted and the memory contents are returned unchecked.

Decomposition:
- Shared package holds the state encoding constants (IDLE=2'd0, LOAD=2'd1, READY=2'd2) and the DATA_W, ADDR_W and N_WORDS defaults.
- One natural sub-module: rj_serial_shifter, containing the shift register, bit counter, frame_err detection and word_done pulse.
- The FSM, write pulse and read handshake stay in the top module.

Test Plan:
1. Reset, load_start, then 16 back-to-back framed words with values 16'h0001·i for i=0..15 -> 16 write pulses at addresses 0..15, each one cycle after bit 16; rj_ready=1 the cycle after the last write; reading address 5 returns 16'h0005 with rd_ack one cycle after rd_req.
2. rd_req held high during LOAD with rd_addr=3 -> rd_ack=0 and read_enable=0 until READY, then granted at latency 1 and returns the loaded word 3.
3. Frame reasserted at bit 8 of word 2 -> frame_err=1, partial word dropped, the new word is written to address 2; rj_ready is reached after 16 complete words.
4. Reset_n=0 after word 7 is written, then a reload with 16'hA5A5 in every word -> outputs 0 during reset, rj_ready=0 until all 16 words are reloaded, and all reads return 16'hA5A5.
5. load_start in READY, followed by a new set -> rj_ready drops the next cycle, frame_err is cleared, and the new values overwrite the old ones at addresses 0..15.
6. Gapped words with 3 idle cycles between frames -> exactly one write pulse per word with mem_frame=write_enable, and no spurious writes during the gaps.

Source files
------------

// File: rtl/rj_load_ctrl_pkg.sv
// rtl/rj_load_ctrl_pkg.sv - shared state encoding and default geometry for the Rj coefficient loader
package rj_load_ctrl_pkg;

   localparam int RJ_DATA_W  = 16;
   localparam int RJ_ADDR_W  = 4;
   localparam int RJ_N_WORDS = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_READY = 2'd2
   } rj_state_e;

endpackage

// File: rtl/rj_serial_shifter.sv
// rtl/rj_serial_shifter.sv - MSB-first framed serial deserializer with mid-word frame error detection
module rj_serial_shifter
   import rj_load_ctrl_pkg::*;
#(
   parameter int DATA_W = RJ_DATA_W
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              enable_i,
   input  logic              restart_i,
   input  logic              frame_i,
   input  logic              bit_i,
   output logic [DATA_W-1:0] word_o,
   output logic              word_done_o,
   output logic              frame_err_o
);

   localparam int CNT_W = $clog2(DATA_W + 1);

   // Only the first DATA_W-1 bits are stored; the final bit joins straight from the input.
   logic [DATA_W-2:0] shift_q, shift_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              err_q, err_d;

   assign word_o      = {shift_q, bit_i};
   assign frame_err_o = err_q;

   always_comb begin
      shift_d     = shift_q;
      cnt_d       = cnt_q;
      err_d       = err_q;
      word_done_o = 1'b0;
      if (restart_i) begin
         shift_d = '0;
         cnt_d   = '0;
         err_d   = 1'b0;
      end else if (!enable_i) begin
         cnt_d = '0;
      end else if (frame_i) begin
         if (cnt_q != '0) err_d = 1'b1;
         shift_d = {shift_q[DATA_W-3:0], bit_i};
         cnt_d   = CNT_W'(1);
      end else if (cnt_q != '0) begin
         shift_d = {shift_q[DATA_W-3:0], bit_i};
         if (cnt_q == CNT_W'(DATA_W - 1)) begin
            word_done_o = 1'b1;
            cnt_d       = '0;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         shift_q <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: rtl/rj_load_ctrl.sv
// rtl/rj_load_ctrl.sv - load/ready sequencer owning the R_MEM write pins and the datapath read handshake
module rj_load_ctrl
   import rj_load_ctrl_pkg::*;
#(
   parameter int DATA_W  = RJ_DATA_W,
   parameter int ADDR_W  = RJ_ADDR_W,
   parameter int N_WORDS = RJ_N_WORDS
) (
   input  logic              Sclk,
   input  logic              Reset_n,
   input  logic              Frame,
   input  logic              InputL,
   input  logic              load_start,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              write_enable,
   output logic              mem_frame,
   output logic [ADDR_W-1:0] Write_Address,
   output logic [DATA_W-1:0] data_in,
   output logic              read_enable,
   output logic [ADDR_W-1:0] Read_Address,
   output logic              rd_ack,
   output logic              rj_ready,
   output logic              busy,
   output logic              frame_err
);

   rj_state_e         state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [ADDR_W-1:0] wa_q, wa_d;
   logic [ADDR_W-1:0] ra_q, ra_d;
   logic [DATA_W-1:0] din_q, din_d;
   logic              we_q, we_d;
   logic              re_q, re_d;
   logic [DATA_W-1:0] word;
   logic              word_done;
   logic              last_word;

   rj_serial_shifter #(
      .DATA_W(DATA_W)
   ) u_shifter (
      .clk_i      (Sclk),
      .rst_ni     (Reset_n),
      .enable_i   (state_q == ST_LOAD),
      .restart_i  (load_start),
      .frame_i    (Frame),
      .bit_i      (InputL),
      .word_o     (word),
      .word_done_o(word_done),
      .frame_err_o(frame_err)
   );

   assign last_word = (cnt_q == ADDR_W'(N_WORDS - 1));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = word_done;
      wa_d    = wa_q;
      din_d   = din_q;
      re_d    = 1'b0;
      ra_d    = ra_q;
      case (state_q)
         ST_IDLE:  if (load_start) state_d = ST_LOAD;
         ST_LOAD:  if (!load_start && we_q && last_word) state_d = ST_READY;
         ST_READY: begin
            if (load_start) begin
               state_d = ST_LOAD;
            end else if (rd_req) begin
               re_d = 1'b1;
               ra_d = rd_addr;
            end
         end
         default:  state_d = ST_IDLE;
      endcase
      // Word count advances at the end of the write cycle, so the address is captured before it moves.
      if (load_start) cnt_d = '0;
      else if (we_q)  cnt_d = last_word ? '0 : cnt_q + ADDR_W'(1);
      if (word_done) begin
         wa_d  = cnt_q;
         din_d = word;
      end
   end

   always_ff @(posedge Sclk) begin
      if (!Reset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         wa_q    <= '0;
         din_q   <= '0;
         re_q    <= 1'b0;
         ra_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         wa_q    <= wa_d;
         din_q   <= din_d;
         re_q    <= re_d;
         ra_q    <= ra_d;
      end
   end

   assign write_enable  = we_q;
   assign mem_frame     = we_q;
   assign Write_Address = wa_q;
   assign data_in       = din_q;
   assign read_enable   = re_q;
   assign Read_Address  = ra_q;
   assign rd_ack        = re_q;
   assign rj_ready      = (state_q == ST_READY);
   assign busy          = (state_q == ST_LOAD);

endmodule
